// File: rtl/fir_out_quantizer.sv
// fir_out_quantizer: round/shift, ReLU, saturate and buffer FIR outputs with credit-style ready.
module fir_out_quantizer #(
  parameter int IN_WIDTH   = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic [3:0]                  shift,
  input  logic                        relu_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [15:0]                 sat_count,
  input  logic                        clr_sat
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int MAX_SH = IN_WIDTH - OUT_WIDTH;
  localparam logic signed [IN_WIDTH:0] MAX_V = (IN_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH:0] MIN_V = ~MAX_V;
  logic s1_v_q, s1_v_d, s1_relu_q, s1_relu_d;
  logic signed [IN_WIDTH:0] s1_r_q, s1_r_d;
  logic s2_v_q, s2_v_d, s2_sat_q, s2_sat_d;
  logic signed [OUT_WIDTH-1:0] s2_y_q, s2_y_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic in_ready_q, in_ready_d;
  logic [15:0] sat_q, sat_d;
  logic signed [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [4:0] sh;
  logic signed [IN_WIDTH:0] ext, rnd, v;
  logic accept, push, pop;
  logic [AW+1:0] occ_d;
  assign in_ready  = in_ready_q;
  assign out_valid = cnt_q != '0;
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
  assign sat_count = sat_q;
  always_comb begin
    accept = in_valid & in_ready_q;
    sh = (int'(shift) > MAX_SH) ? 5'(MAX_SH) : {1'b0, shift};
    ext = {in_data[IN_WIDTH-1], in_data};
    rnd = (sh == 5'd0) ? '0 : (IN_WIDTH+1)'(1) << (sh - 5'd1);
    s1_v_d = accept;
    s1_r_d = (ext + rnd) >>> sh;
    s1_relu_d = relu_en;
    v = (s1_relu_q && s1_r_q[IN_WIDTH]) ? '0 : s1_r_q;
    s2_v_d = s1_v_q;
    s2_sat_d = s1_v_q && (v > MAX_V || v < MIN_V);
    s2_y_d = (v > MAX_V) ? MAX_V[OUT_WIDTH-1:0] : (v < MIN_V) ? MIN_V[OUT_WIDTH-1:0] : v[OUT_WIDTH-1:0];
    push = s2_v_q;
    pop = out_valid & out_ready;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    // Samples still in the pipeline reserve a FIFO slot, so the stages never need to stall.
    occ_d = (AW+2)'(cnt_d) + (AW+2)'(s1_v_d) + (AW+2)'(s2_v_d);
    in_ready_d = occ_d < (AW+2)'(FIFO_DEPTH);
    sat_d = clr_sat ? '0 : (s2_sat_q && sat_q != 16'hFFFF) ? sat_q + 16'd1 : sat_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_relu_q  <= 1'b0;
      s1_r_q     <= '0;
      s2_v_q     <= 1'b0;
      s2_sat_q   <= 1'b0;
      s2_y_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      sat_q      <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_relu_q  <= s1_relu_d;
      s1_r_q     <= s1_r_d;
      s2_v_q     <= s2_v_d;
      s2_sat_q   <= s2_sat_d;
      s2_y_q     <= s2_y_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      sat_q      <= sat_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s2_y_q;
  end
endmodule
